// File: rtl/mul_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl_if
// Bundles the handshake and datapath signals of the sequential shift-add
// multiplier controller.
//
//   start     master -> slave   request one multiplication
//   a         master -> slave   8-bit multiplicand
//   m         master -> slave   8-bit multiplier
//   prod_in   master -> slave   16-bit running product from the datapath
//   dp_clr_n  slave  -> master  active-low datapath clear
//   test      slave  -> master  current multiplier bit (adder gate)
//   mcand     slave  -> master  latched multiplicand
//   busy      slave  -> master  operation in progress
//   done      slave  -> master  one-cycle result-updated pulse
//   result    slave  -> master  captured 16-bit product
// ---------------------------------------------------------------------------
interface mul_seq_ctrl_if;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  m;
   logic [15:0] prod_in;
   logic        dp_clr_n;
   logic        test;
   logic [7:0]  mcand;
   logic        busy;
   logic        done;
   logic [15:0] result;

   modport master (
      output start, a, m, prod_in,
      input  dp_clr_n, test, mcand, busy, done, result
   );

   modport slave (
      input  start, a, m, prod_in,
      output dp_clr_n, test, mcand, busy, done, result
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
// Controller for an external 8x8 shift-add multiplier datapath. On an
// accepted start it latches the operands, clears the datapath for one cycle,
// walks the multiplier LSB first for eight cycles (presenting each bit on
// test), then captures the datapath product into result and pulses done.
//
// Ports
//   clk    sole clock, rising edge
//   reset  synchronous active-low reset
//   bus    mul_seq_ctrl_if.slave (start/a/m/prod_in in,
//          dp_clr_n/test/mcand/busy/done/result out)
// ---------------------------------------------------------------------------
module mul_seq_ctrl (
   input logic           clk,
   input logic           reset,
   mul_seq_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_STEP    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]  state;
   logic [7:0]  mcand_q;
   logic [7:0]  mult_sr;   // multiplier, shifted right once per step
   logic [2:0]  step_cnt;
   logic [15:0] result_q;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         mcand_q  <= '0;
         mult_sr  <= '0;
         step_cnt <= '0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state    <= S_CLEAR;
                  mcand_q  <= bus.a;
                  mult_sr  <= bus.m;
                  step_cnt <= '0;
               end else begin
                  state    <= S_IDLE;
               end
            end
            S_CLEAR: state <= S_STEP;
            S_STEP: begin
               mult_sr <= mult_sr >> 1;
               // Leave on the eighth step; the counter parks at 7 rather
               // than wrapping so it can never describe a ninth step.
               if (step_cnt == 3'd7) begin
                  state <= S_CAPTURE;
               end else begin
                  step_cnt <= step_cnt + 3'd1;
               end
            end
            S_CAPTURE: begin
               // The datapath has absorbed the last partial product by now.
               result_q <= bus.prod_in;
               state    <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Start requests are only looked at in IDLE/DONE, so a start while busy
   // leaves operands, counter and state untouched.
   assign bus.test     = (state == S_STEP) & mult_sr[0];
   assign bus.busy     = (state == S_CLEAR) | (state == S_STEP) | (state == S_CAPTURE);
   assign bus.done     = (state == S_DONE);
   // Reset drives the clear directly so the datapath clears on the same edge.
   assign bus.dp_clr_n = reset & (state != S_CLEAR);
   assign bus.mcand    = mcand_q;
   assign bus.result   = result_q;

endmodule
